// File: rtl/mips_mc_ctrl.sv
// Multi-cycle main controller for the 32-bit MIPS datapath.
// Sequences one instruction over several cycles. Memory accesses use a
// ready handshake with a bounded wait (MEM_TIMEOUT, 0 = unbounded).
// Optional build macro MIPS_MC_CTRL_PERF_EN adds a retired-instruction
// counter output instr_cnt_o.
module mips_mc_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode_i,
    input  logic             zero_i,
    input  logic             mem_ready_i,
    output logic             mem_rd_o,
    output logic             mem_wr_o,
    output logic             sel_iord_o,
    output logic             sel_alusrca_o,
    output logic [1:0]       sel_alusrcb_o,
    output logic [1:0]       sel_pcsrc_o,
    output logic             sel_memtoreg_o,
    output logic             sel_regdst_o,
    output logic [1:0]       alu_op_o,
    output logic             pc_we_o,
    output logic             ir_we_o,
    output logic             reg_we_o,
    output logic             illegal_op_o,
    output logic             mem_err_o,
    output logic [3:0]       state_o
`ifdef MIPS_MC_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] instr_cnt_o
`endif
);

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpJ     = 6'b000010;

    // Counter only has to hold 0 .. MEM_TIMEOUT-1; hitting the last value
    // without ready is the timeout.
    localparam int unsigned WaitW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WaitW-1:0] WaitLast =
        WaitW'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 32'd0);

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExec   = 4'd6,
        StAluWb  = 4'd7,
        StBranch = 4'd8,
        StAddiEx = 4'd9,
        StAddiWb = 4'd10,
        StJump   = 4'd11,
        StTrap   = 4'd12
    } state_e;

    // Moore part of the outputs, registered from the next state.
    typedef struct packed {
        logic       mem_rd;
        logic       mem_wr;
        logic       iord;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic       memtoreg;
        logic       regdst;
        logic [1:0] alu_op;
        logic       pc_we;
        logic       reg_we;
        logic       illegal_op;
    } ctrl_t;

    state_e             state_q, state_d;
    logic [WaitW-1:0]   wait_cnt_q, wait_cnt_d;
    ctrl_t              ctrl_q;
    logic               mem_err_q;
    logic               strobe;
    logic               handshake;
    logic               timeout;
    logic               fetch_done;

    function automatic ctrl_t decode_ctrl(input state_e st);
        ctrl_t c;
        c = '0;
        case (st)
            StFetch: begin
                c.mem_rd  = 1'b1;
                c.alusrcb = 2'b01;
            end
            StDecode: c.alusrcb = 2'b11;
            StMemAdr, StAddiEx: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            StMemRd: begin
                c.mem_rd = 1'b1;
                c.iord   = 1'b1;
            end
            StMemWb: begin
                c.memtoreg = 1'b1;
                c.reg_we   = 1'b1;
            end
            StMemWr: begin
                c.mem_wr = 1'b1;
                c.iord   = 1'b1;
            end
            StExec: begin
                c.alusrca = 1'b1;
                c.alu_op  = 2'b10;
            end
            StAluWb: begin
                c.regdst = 1'b1;
                c.reg_we = 1'b1;
            end
            StBranch: begin
                c.alusrca = 1'b1;
                c.alu_op  = 2'b01;
                c.pcsrc   = 2'b01;
            end
            StAddiWb: c.reg_we = 1'b1;
            StJump: begin
                c.pcsrc = 2'b10;
                c.pc_we = 1'b1;
            end
            StTrap: c.illegal_op = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    // Next-state, handshake/timeout detection and wait-counter update.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        // Strobe registers are zero right after reset or a timeout, so
        // mem_ready is ignored in that cycle and FETCH simply restarts.
        strobe     = ctrl_q.mem_rd | ctrl_q.mem_wr;
        handshake  = strobe & mem_ready_i;
        timeout    = (MEM_TIMEOUT != 0) && strobe && !mem_ready_i &&
                     (wait_cnt_q == WaitLast);

        case (state_q)
            StFetch: begin
                if (handshake) state_d = StDecode;
            end
            StDecode: begin
                case (opcode_i)
                    OpRtype:   state_d = StExec;
                    OpLw, OpSw: state_d = StMemAdr;
                    OpBeq:     state_d = StBranch;
                    OpAddi:    state_d = StAddiEx;
                    OpJ:       state_d = StJump;
                    default:   state_d = StTrap;
                endcase
            end
            StMemAdr: state_d = (opcode_i == OpSw) ? StMemWr : StMemRd;
            StMemRd: begin
                if (handshake) state_d = StMemWb;
            end
            StMemWr: begin
                if (handshake) state_d = StFetch;
            end
            StExec:   state_d = StAluWb;
            StAddiEx: state_d = StAddiWb;
            default:  state_d = StFetch;
        endcase

        if (timeout) state_d = StFetch;

        if (timeout || (state_d != state_q)) begin
            wait_cnt_d = '0;
        end else if ((MEM_TIMEOUT != 0) && strobe && !mem_ready_i) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    // State, wait counter and registered Moore outputs; a timeout blanks all
    // outputs for one cycle while mem_err is raised.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StFetch;
            wait_cnt_q <= '0;
            ctrl_q     <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            ctrl_q     <= timeout ? '0 : decode_ctrl(state_d);
            mem_err_q  <= timeout;
        end
    end

    assign fetch_done = (state_q == StFetch) & handshake;

    assign mem_rd_o       = ctrl_q.mem_rd;
    assign mem_wr_o       = ctrl_q.mem_wr;
    assign sel_iord_o     = ctrl_q.iord;
    assign sel_alusrca_o  = ctrl_q.alusrca;
    assign sel_alusrcb_o  = ctrl_q.alusrcb;
    assign sel_pcsrc_o    = ctrl_q.pcsrc;
    assign sel_memtoreg_o = ctrl_q.memtoreg;
    assign sel_regdst_o   = ctrl_q.regdst;
    assign alu_op_o       = ctrl_q.alu_op;
    assign reg_we_o       = ctrl_q.reg_we;
    assign illegal_op_o   = ctrl_q.illegal_op;
    assign mem_err_o      = mem_err_q;
    assign state_o        = state_q;
    assign ir_we_o        = fetch_done;
    assign pc_we_o        = fetch_done | ctrl_q.pc_we | ((state_q == StBranch) & zero_i);

`ifdef MIPS_MC_CTRL_PERF_EN
    logic [CNT_W-1:0] instr_cnt_q;

    // Count every instruction load into IR; wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_cnt_q <= '0;
        end else if (fetch_done) begin
            instr_cnt_q <= instr_cnt_q + 1'b1;
        end
    end

    assign instr_cnt_o = instr_cnt_q;
`else
    logic unused_cnt_w;
    assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Table-driven bench for mips_mc_ctrl, built with MEM_TIMEOUT=4.
module tb_mips_mc_ctrl;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       mem_rd, mem_wr, sel_iord, sel_alusrca, sel_memtoreg, sel_regdst;
    logic [1:0] sel_alusrcb, sel_pcsrc, alu_op;
    logic       pc_we, ir_we, reg_we, illegal_op, mem_err;
    logic [3:0] state;
`ifdef MIPS_MC_CTRL_PERF_EN
    logic [31:0] instr_cnt;
    int unsigned cnt_model;
`endif

    int n_cmp;
    int n_bad;

    mips_mc_ctrl #(
        .MEM_TIMEOUT(4),
        .CNT_W      (32)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode_i      (opcode),
        .zero_i        (zero),
        .mem_ready_i   (mem_ready),
        .mem_rd_o      (mem_rd),
        .mem_wr_o      (mem_wr),
        .sel_iord_o    (sel_iord),
        .sel_alusrca_o (sel_alusrca),
        .sel_alusrcb_o (sel_alusrcb),
        .sel_pcsrc_o   (sel_pcsrc),
        .sel_memtoreg_o(sel_memtoreg),
        .sel_regdst_o  (sel_regdst),
        .alu_op_o      (alu_op),
        .pc_we_o       (pc_we),
        .ir_we_o       (ir_we),
        .reg_we_o      (reg_we),
        .illegal_op_o  (illegal_op),
        .mem_err_o     (mem_err),
        .state_o       (state)
`ifdef MIPS_MC_CTRL_PERF_EN
        ,
        .instr_cnt_o   (instr_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output vector: rd wr iord asa | asb | pcs | mtr rdst | aop | pcwe irwe rwe ill err
    localparam logic [16:0] IDLE = 17'b0000_00_00_00_00_00000;
    localparam logic [16:0] F_RD = 17'b1000_01_00_00_00_00000;
    localparam logic [16:0] F_OK = 17'b1000_01_00_00_00_11000;
    localparam logic [16:0] DEC  = 17'b0000_11_00_00_00_00000;
    localparam logic [16:0] EXE  = 17'b0001_00_00_00_10_00000;
    localparam logic [16:0] AWB  = 17'b0000_00_00_01_00_00100;
    localparam logic [16:0] MADR = 17'b0001_10_00_00_00_00000;
    localparam logic [16:0] MRD  = 17'b1010_00_00_00_00_00000;
    localparam logic [16:0] MWB  = 17'b0000_00_00_10_00_00100;
    localparam logic [16:0] MWR  = 17'b0110_00_00_00_00_00000;
    localparam logic [16:0] BR0  = 17'b0001_00_01_00_01_00000;
    localparam logic [16:0] BR1  = 17'b0001_00_01_00_01_10000;
    localparam logic [16:0] JMP  = 17'b0000_00_10_00_00_10000;
    localparam logic [16:0] AIWB = 17'b0000_00_00_00_00_00100;
    localparam logic [16:0] TRP  = 17'b0000_00_00_00_00_00010;
    localparam logic [16:0] ERR  = 17'b0000_00_00_00_00_00001;

    localparam logic [5:0] R  = 6'b000000;
    localparam logic [5:0] LW = 6'b100011;
    localparam logic [5:0] SW = 6'b101011;
    localparam logic [5:0] BQ = 6'b000100;
    localparam logic [5:0] AI = 6'b001000;
    localparam logic [5:0] JJ = 6'b000010;
    localparam logic [5:0] XX = 6'b111111;

    typedef struct {
        logic [5:0]  op;
        logic        z;
        logic        rdy;
        logic [3:0]  st;
        logic [16:0] out;
    } vec_t;

    localparam int NV = 51;
    vec_t vecs [NV];

    function automatic logic [16:0] act_out();
        return {mem_rd, mem_wr, sel_iord, sel_alusrca, sel_alusrcb, sel_pcsrc,
                sel_memtoreg, sel_regdst, alu_op, pc_we, ir_we, reg_we, illegal_op, mem_err};
    endfunction

    task automatic check_vec(input string name, input logic [3:0] st, input logic [16:0] out);
        n_cmp++;
        if (state !== st) begin
            n_bad++;
            $display("FAIL %s state: got %0d want %0d", name, state, st);
        end
        n_cmp++;
        if (act_out() !== out) begin
            n_bad++;
            $display("FAIL %s outputs: got %b want %b", name, act_out(), out);
        end
    endtask

    task automatic setv(input int i, input logic [5:0] op, input logic z, input logic rdy,
                        input logic [3:0] st, input logic [16:0] out);
        vecs[i] = '{op, z, rdy, st, out};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;

        // Post-reset idle cycle: ready ignored, nothing moves.
        setv(0,  R,  0, 1, 0,  IDLE);
        // R-type
        setv(1,  R,  0, 1, 0,  F_OK);
        setv(2,  R,  0, 0, 1,  DEC);
        setv(3,  R,  0, 0, 6,  EXE);
        setv(4,  R,  0, 0, 7,  AWB);
        // lw, ready on the 4th MEMRD cycle (counter at limit -> success)
        setv(5,  LW, 0, 1, 0,  F_OK);
        setv(6,  LW, 0, 0, 1,  DEC);
        setv(7,  LW, 0, 0, 2,  MADR);
        setv(8,  LW, 0, 0, 3,  MRD);
        setv(9,  LW, 0, 0, 3,  MRD);
        setv(10, LW, 0, 0, 3,  MRD);
        setv(11, LW, 0, 1, 3,  MRD);
        setv(12, LW, 0, 0, 4,  MWB);
        // beq not taken / taken
        setv(13, BQ, 0, 1, 0,  F_OK);
        setv(14, BQ, 1, 0, 1,  DEC);
        setv(15, BQ, 0, 0, 8,  BR0);
        setv(16, BQ, 0, 1, 0,  F_OK);
        setv(17, BQ, 0, 0, 1,  DEC);
        setv(18, BQ, 1, 0, 8,  BR1);
        // illegal opcode
        setv(19, XX, 0, 1, 0,  F_OK);
        setv(20, XX, 0, 0, 1,  DEC);
        setv(21, XX, 0, 1, 12, TRP);
        // j
        setv(22, JJ, 0, 1, 0,  F_OK);
        setv(23, JJ, 0, 0, 1,  DEC);
        setv(24, JJ, 0, 0, 11, JMP);
        // addi
        setv(25, AI, 0, 1, 0,  F_OK);
        setv(26, AI, 0, 0, 1,  DEC);
        setv(27, AI, 0, 1, 9,  MADR);
        setv(28, AI, 0, 0, 10, AIWB);
        // sw, ready on 2nd write cycle
        setv(29, SW, 0, 1, 0,  F_OK);
        setv(30, SW, 0, 0, 1,  DEC);
        setv(31, SW, 0, 0, 2,  MADR);
        setv(32, SW, 0, 0, 5,  MWR);
        setv(33, SW, 0, 1, 5,  MWR);
        // sw timeout: 4 write cycles, then error cycle (ready ignored)
        setv(34, SW, 0, 1, 0,  F_OK);
        setv(35, SW, 0, 0, 1,  DEC);
        setv(36, SW, 0, 0, 2,  MADR);
        setv(37, SW, 0, 0, 5,  MWR);
        setv(38, SW, 0, 0, 5,  MWR);
        setv(39, SW, 0, 0, 5,  MWR);
        setv(40, SW, 0, 0, 5,  MWR);
        setv(41, SW, 0, 1, 0,  ERR);
        // fetch timeout restarts fetch
        setv(42, SW, 0, 0, 0,  F_RD);
        setv(43, SW, 0, 0, 0,  F_RD);
        setv(44, SW, 0, 0, 0,  F_RD);
        setv(45, SW, 0, 0, 0,  F_RD);
        setv(46, SW, 0, 0, 0,  ERR);
        // recover and park in MEMWR for the reset test
        setv(47, SW, 0, 1, 0,  F_OK);
        setv(48, SW, 0, 0, 1,  DEC);
        setv(49, SW, 0, 0, 2,  MADR);
        setv(50, SW, 0, 0, 5,  MWR);

        rst_n     = 1'b0;
        opcode    = R;
        zero      = 1'b0;
        mem_ready = 1'b0;
        #1;
        check_vec("reset", 4'd0, IDLE);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
`ifdef MIPS_MC_CTRL_PERF_EN
        cnt_model = 0;
`endif

        for (int i = 0; i < NV; i++) begin
            if (i != 0) @(negedge clk);
            opcode    = vecs[i].op;
            zero      = vecs[i].z;
            mem_ready = vecs[i].rdy;
            #1;
            check_vec($sformatf("vec%0d", i), vecs[i].st, vecs[i].out);
`ifdef MIPS_MC_CTRL_PERF_EN
            n_cmp++;
            if (instr_cnt !== cnt_model) begin
                n_bad++;
                $display("FAIL vec%0d instr_cnt: got %0d want %0d", i, instr_cnt, cnt_model);
            end
            if (vecs[i].out[3]) cnt_model++;
`endif
        end

        // Async reset mid-MEMWR, checked before any clock edge.
        #1;
        rst_n = 1'b0;
        #1;
        check_vec("async_reset", 4'd0, IDLE);
`ifdef MIPS_MC_CTRL_PERF_EN
        n_cmp++;
        if (instr_cnt !== 32'd0) begin
            n_bad++;
            $display("FAIL reset instr_cnt: got %0d want 0", instr_cnt);
        end
`endif
        @(posedge clk);
        #1;
        check_vec("held_reset", 4'd0, IDLE);
        @(negedge clk);
        rst_n     = 1'b1;
        mem_ready = 1'b1;
        #1;
        check_vec("post_reset_idle", 4'd0, IDLE);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        check_vec("post_reset_fetch", 4'd0, F_RD);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
